// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and helpers for the LSU store buffer: size
//            encodings, strobe base patterns, the buffer entry struct, and
//            alignment / lane-placement helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // The strobe is four byte lanes wide, so the datapath is fixed at 32 bits.
    localparam int c_XLEN = 32;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    localparam logic [3:0] c_STRB_BYTE = 4'b0001;
    localparam logic [3:0] c_STRB_HALF = 4'b0011;
    localparam logic [3:0] c_STRB_WORD = 4'b1111;

    // One buffered store: word address, lane-placed data and byte strobe.
    typedef struct packed {
        logic              valid;
        logic [c_XLEN-1:0] addr;
        logic [c_XLEN-1:0] data;
        logic [3:0]        strb;
    } sb_entry_t;

    // Lane pattern for an access starting at byte 0 of the word.
    // The reserved size 2'b11 touches no lanes.
    function automatic logic [3:0] strb_base(input logic [1:0] size);
        case (size)
            c_SIZE_BYTE: strb_base = c_STRB_BYTE;
            c_SIZE_HALF: strb_base = c_STRB_HALF;
            c_SIZE_WORD: strb_base = c_STRB_WORD;
            default:     strb_base = 4'b0000;
        endcase
    endfunction

    // Natural alignment check; the reserved size is treated as misaligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            c_SIZE_BYTE: is_aligned = 1'b1;
            c_SIZE_HALF: is_aligned = ~off[0];
            c_SIZE_WORD: is_aligned = (off == 2'b00);
            default:     is_aligned = 1'b0;
        endcase
    endfunction

    // Replicate a byte or half across the word so the strobed lanes carry it.
    function automatic logic [c_XLEN-1:0] lane_place(input logic [1:0] size,
                                                     input logic [c_XLEN-1:0] raw);
        case (size)
            c_SIZE_BYTE: lane_place = {4{raw[7:0]}};
            c_SIZE_HALF: lane_place = {2{raw[15:0]}};
            default:     lane_place = raw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_merge.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_merge
// Purpose  : Per byte lane, pick the youngest valid store-buffer entry whose
//            word address matches the load and whose strobe covers the lane.
//            Entries are walked oldest-to-youngest from the head so that a
//            later match overrides an earlier one.
// Revision : 1.0 - initial release
// ============================================================================
module sb_fwd_merge
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [c_XLEN-1:0]          word_addr,
    output logic [3:0]                 lane_hit,
    output logic [c_XLEN-1:0]          lane_data
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0] w_idx;

    // Oldest-to-youngest scan; the last writer of each lane wins.
    always_comb begin
        lane_hit  = '0;
        lane_data = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + c_PW'(i);
            if (entries[w_idx].valid && (entries[w_idx].addr == word_addr)) begin
                for (int l = 0; l < 4; l++) begin
                    if (entries[w_idx].strb[l]) begin
                        lane_hit[l]        = 1'b1;
                        lane_data[l*8 +: 8] = entries[w_idx].data[l*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_store_buffer
// Purpose  : Circular store buffer between the LSU and memory. Stores are
//            lane-placed on entry, drained in order from the head, and loads
//            query the buffer for store-to-load forwarding or a stall.
//            Macro STORE_BUFFER_FWD_EN enables byte-lane forwarding; without
//            it any address-matching load reports a conflict.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    // store enqueue
    input  logic            enq_valid,
    output logic            enq_ready,
    input  logic [XLEN-1:0] enq_addr,
    input  logic [XLEN-1:0] enq_data,
    input  logic [1:0]      enq_size,
    output logic            misaligned_err,
    // load query
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ld_data,
    output logic            ld_fwd_hit,
    output logic            ld_conflict,
    // drain
    output logic            mem_wr_valid,
    input  logic            mem_wr_ready,
    output logic [XLEN-1:0] mem_wr_addr,
    output logic [XLEN-1:0] mem_wr_data,
    output logic [3:0]      mem_wr_strb,
    output logic            empty
);

    localparam int c_PW = $clog2(DEPTH);

    sb_entry_t       r_entries [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_PW:0]   r_count;
    logic            r_mis_err;

    logic            w_enq_aligned;
    logic            w_push;
    logic            w_pop;
    logic            w_ld_aligned;
    logic [3:0]      w_need;
    logic [3:0]      w_lane_hit;
    logic [XLEN-1:0] w_lane_data;
    logic [3:0]      w_use_lane;
    logic [XLEN-1:0] w_merged;
    logic [XLEN-1:0] w_shifted;

    assign enq_ready      = (r_count < (c_PW+1)'(DEPTH));
    assign w_enq_aligned  = is_aligned(enq_size, enq_addr[1:0]);
    assign w_push         = enq_valid && enq_ready && w_enq_aligned;
    assign w_pop          = mem_wr_valid && mem_wr_ready;

    assign mem_wr_valid   = (r_count != '0);
    assign empty          = (r_count == '0);
    assign mem_wr_addr    = r_entries[r_head].addr;
    assign mem_wr_data    = r_entries[r_head].data;
    assign mem_wr_strb    = r_entries[r_head].strb;
    assign misaligned_err = r_mis_err;

    // FIFO pointers, occupancy, entry writes/retirement and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_mis_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            r_mis_err <= enq_valid && enq_ready && !w_enq_aligned;
            if (w_push) begin
                r_entries[r_tail].valid <= 1'b1;
                r_entries[r_tail].addr  <= {enq_addr[XLEN-1:2], 2'b00};
                r_entries[r_tail].data  <= lane_place(enq_size, enq_data);
                r_entries[r_tail].strb  <= strb_base(enq_size) << enq_addr[1:0];
                r_tail                  <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_ld_aligned = is_aligned(ld_size, ld_addr[1:0]);
    assign w_need       = w_ld_aligned ? (strb_base(ld_size) << ld_addr[1:0]) : 4'b0000;

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .entries   (r_entries),
        .head      (r_head),
        .word_addr ({ld_addr[XLEN-1:2], 2'b00}),
        .lane_hit  (w_lane_hit),
        .lane_data (w_lane_data)
    );

`ifdef STORE_BUFFER_FWD_EN
    // Forward covered lanes; partial coverage forces the load to stall.
    always_comb begin
        w_use_lane  = w_lane_hit & w_need;
        ld_fwd_hit  = ld_valid && w_ld_aligned && (w_use_lane == w_need);
        ld_conflict = ld_valid && w_ld_aligned && (w_use_lane != 4'b0000)
                      && (w_use_lane != w_need);
    end
`else
    // No forwarding: any word-address match against a live entry stalls.
    always_comb begin
        w_use_lane  = 4'b0000;
        ld_fwd_hit  = 1'b0;
        ld_conflict = ld_valid && (w_lane_hit != 4'b0000);
    end
`endif

    // Lane merge, right-align to byte 0, then sign/zero extend.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_merged[l*8 +: 8] = w_use_lane[l] ? w_lane_data[l*8 +: 8] : mem_rdata[l*8 +: 8];
        end
        w_shifted = w_merged >> {ld_addr[1:0], 3'b000};
        if (!w_ld_aligned) begin
            ld_data = '0;
        end else begin
            case (ld_size)
                c_SIZE_BYTE: ld_data = {{24{w_shifted[7]  & ~ld_unsigned}}, w_shifted[7:0]};
                c_SIZE_HALF: ld_data = {{16{w_shifted[15] & ~ld_unsigned}}, w_shifted[15:0]};
                default:     ld_data = w_shifted;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_store_buffer
// Purpose  : Directed self-checking bench for lsu_store_buffer (DEPTH=4).
//            Expectations follow STORE_BUFFER_FWD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_store_buffer;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, enq_ready;
    logic [31:0] enq_addr, enq_data;
    logic [1:0]  enq_size;
    logic        misaligned_err;
    logic        ld_valid, ld_unsigned;
    logic [31:0] ld_addr, mem_rdata, ld_data;
    logic [1:0]  ld_size;
    logic        ld_fwd_hit, ld_conflict;
    logic        mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        empty;

    int errors = 0;
    int checks = 0;

    lsu_store_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_size(enq_size), .misaligned_err(misaligned_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .mem_rdata(mem_rdata), .ld_data(ld_data),
        .ld_fwd_hit(ld_fwd_hit), .ld_conflict(ld_conflict),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_addr  = a;
        enq_data  = d;
        enq_size  = s;
        enq_valid = 1'b1;
        @(posedge clk); #1;
        enq_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u,
                        input logic [31:0] m);
        ld_addr     = a;
        ld_size     = s;
        ld_unsigned = u;
        mem_rdata   = m;
        ld_valid    = 1'b1;
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        mem_wr_ready = 1'b1;
        while (!empty && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        mem_wr_ready = 1'b0;
        chk("drain_empty", {31'b0, empty}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_size = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0;
        mem_rdata = '0; mem_wr_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_mem_wr_valid", {31'b0, mem_wr_valid}, 32'd0);
        chk("rst_mis_err", {31'b0, misaligned_err}, 32'd0);
        rst = 1'b0;

        // SB to 0x1003 lands in lane 3 of word 0x1000
        enq(32'h1003, 32'h0000_00AB, B);
        chk("sb_valid", {31'b0, mem_wr_valid}, 32'd1);
        chk("sb_addr", mem_wr_addr, 32'h1000);
        chk("sb_strb", {28'b0, mem_wr_strb}, 32'h8);
        chk("sb_data_hi", {24'b0, mem_wr_data[31:24]}, 32'hAB);
        drain();

        // SW then SB into the same word
        enq(32'h2000, 32'h1122_3344, W);
        enq(32'h2001, 32'h0000_0055, B);
        chk("head_addr", mem_wr_addr, 32'h2000);
        chk("head_data", mem_wr_data, 32'h1122_3344);
        chk("head_strb", {28'b0, mem_wr_strb}, 32'hF);
        load(32'h2000, W, 1'b0, 32'hDEAD_BEEF);
`ifdef STORE_BUFFER_FWD_EN
        chk("lw2000_hit", {31'b0, ld_fwd_hit}, 32'd1);
        chk("lw2000_conf", {31'b0, ld_conflict}, 32'd0);
        chk("lw2000_data", ld_data, 32'h1122_5544);
`else
        chk("lw2000_hit", {31'b0, ld_fwd_hit}, 32'd0);
        chk("lw2000_conf", {31'b0, ld_conflict}, 32'd1);
        chk("lw2000_data", ld_data, 32'hDEAD_BEEF);
`endif
        load(32'h2003, B, 1'b1, 32'hDEAD_BEEF);
`ifdef STORE_BUFFER_FWD_EN
        chk("lbu2003_data", ld_data, 32'h0000_0011);
`else
        chk("lbu2003_data", ld_data, 32'h0000_00DE);
`endif
        load(32'h5000, W, 1'b0, 32'hCAFE_F00D);
        chk("lw5000_hit", {31'b0, ld_fwd_hit}, 32'd0);
        chk("lw5000_conf", {31'b0, ld_conflict}, 32'd0);
        chk("lw5000_data", ld_data, 32'hCAFE_F00D);
        load(32'h2000, W, 1'b0, 32'hDEAD_BEEF);
        ld_valid = 1'b0;
        #1;
        chk("gated_conf", {31'b0, ld_conflict}, 32'd0);
        chk("gated_hit", {31'b0, ld_fwd_hit}, 32'd0);
        @(posedge clk); #1;
        chk("stall_addr", mem_wr_addr, 32'h2000);
        chk("stall_data", mem_wr_data, 32'h1122_3344);
        drain();

        // SH 0x8001 to 0x3000, then half/word loads
        enq(32'h3000, 32'h0000_8001, H);
        load(32'h3000, H, 1'b0, 32'hA5A5_C3C3);
`ifdef STORE_BUFFER_FWD_EN
        chk("lh3000_data", ld_data, 32'hFFFF_8001);
`else
        chk("lh3000_data", ld_data, 32'hFFFF_C3C3);
`endif
        load(32'h3000, H, 1'b1, 32'hA5A5_C3C3);
`ifdef STORE_BUFFER_FWD_EN
        chk("lhu3000_data", ld_data, 32'h0000_8001);
`else
        chk("lhu3000_data", ld_data, 32'h0000_C3C3);
`endif
        load(32'h3000, W, 1'b0, 32'hA5A5_C3C3);
        chk("lw3000_conf", {31'b0, ld_conflict}, 32'd1);
        chk("lw3000_hit", {31'b0, ld_fwd_hit}, 32'd0);
        load(32'h3002, H, 1'b0, 32'hA5A5_C3C3);
        chk("lh3002_data", ld_data, 32'hFFFF_A5A5);
        load(32'h3001, W, 1'b0, 32'hA5A5_C3C3);
        chk("misld_data", ld_data, 32'h0);
        chk("misld_hit", {31'b0, ld_fwd_hit}, 32'd0);
`ifdef STORE_BUFFER_FWD_EN
        chk("misld_conf", {31'b0, ld_conflict}, 32'd0);
`endif
        ld_valid = 1'b0;
        drain();

        // misaligned store is dropped with a one-cycle error pulse
        enq(32'h4002, 32'h1234_5678, W);
        chk("mis_err_hi", {31'b0, misaligned_err}, 32'd1);
        chk("mis_empty", {31'b0, empty}, 32'd1);
        @(posedge clk); #1;
        chk("mis_err_lo", {31'b0, misaligned_err}, 32'd0);
        enq(32'h4000, 32'h0BAD_F00D, W);
        chk("sw4000_addr", mem_wr_addr, 32'h4000);
        drain();

        // fill to DEPTH with pointers starting mid-ring, then drain in order
        for (int k = 0; k < 4; k++) begin
            enq(32'h100 + 32'(4*k), 32'hA0 + 32'(k), W);
        end
        chk("full_ready", {31'b0, enq_ready}, 32'd0);
        enq(32'h200, 32'hFFFF_FFFF, W);
        chk("full_fifth_ready", {31'b0, enq_ready}, 32'd0);
        chk("full_head", mem_wr_addr, 32'h100);
        chk("full_head_data", mem_wr_data, 32'hA0);
        mem_wr_ready = 1'b1;
        @(posedge clk); #1;
        mem_wr_ready = 1'b0;
        chk("pop1_ready", {31'b0, enq_ready}, 32'd1);
        chk("pop1_addr", mem_wr_addr, 32'h104);
        chk("pop1_data", mem_wr_data, 32'hA1);
        mem_wr_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            @(posedge clk); #1;
            chk("order_addr", mem_wr_addr, 32'h100 + 32'(4*k));
            chk("order_data", mem_wr_data, 32'hA0 + 32'(k));
        end
        @(posedge clk); #1;
        chk("order_empty", {31'b0, empty}, 32'd1);
        mem_wr_ready = 1'b0;

        // reset with three stores pending discards them
        enq(32'h500, 32'h1, W);
        enq(32'h504, 32'h2, W);
        enq(32'h508, 32'h3, W);
        chk("pend_valid", {31'b0, mem_wr_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_empty", {31'b0, empty}, 32'd1);
        chk("midrst_valid", {31'b0, mem_wr_valid}, 32'd0);
        chk("midrst_ready", {31'b0, enq_ready}, 32'd1);
        mem_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_write", {31'b0, mem_wr_valid}, 32'd0);
        mem_wr_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
